// File: rtl/audio_i2s_tx.sv
// I2S transmitter: divides clk into BCLK, serialises {left,right} MSB first with
// the one-BCLK data delay after each LRCK edge, and buffers one pending sample.
module audio_i2s_tx #(
  parameter int WIDTH    = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             audio_en,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             i2s_bclk,
  output logic             i2s_lrck,
  output logic             i2s_data,
  output logic             sample_req,
  output logic             underrun,
  output logic             overrun
);

  localparam int FW = 2 * WIDTH;
  localparam int CW = $clog2(FW);
  localparam int PW = $clog2(BCLK_DIV);

  localparam logic [PW-1:0] PRESC_LAST = PW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FW - 1);
  localparam logic [CW-1:0] CNT_RIGHT  = CW'(WIDTH);

  logic [PW-1:0] r_presc;
  logic          r_bclk;
  logic          r_lrck;
  logic          r_data;
  logic [CW-1:0] r_bit_cnt;
  logic [FW-1:0] r_shreg;
  logic [FW-1:0] r_hold;
  logic [FW-1:0] r_last;
  logic          r_hold_valid;
  logic          r_sample_req;
  logic          r_underrun;
  logic          r_overrun;

  logic          w_tc;
  logic          w_fall;
  logic          w_load;
  logic [CW-1:0] w_cnt_next;
  logic [FW-1:0] w_sample;
  logic [FW-1:0] w_frame;

  assign w_tc       = (r_presc == PRESC_LAST);
  assign w_fall     = w_tc && r_bclk;
  assign w_load     = w_fall && (r_bit_cnt == CNT_LAST);
  assign w_cnt_next = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_sample   = {left, right};

  // A strobe coinciding with the load wins over hold; otherwise hold, else repeat.
  always_comb begin
    // NOTE: default first so every path assigns w_frame and no latch is inferred.
    w_frame = r_last;
    if (audio_en)          w_frame = w_sample;
    else if (r_hold_valid) w_frame = r_hold;
  end

  // NOTE: the sample buffers are reset too, so an aborted frame can never replay stale audio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_bclk    <= 1'b0;
      r_lrck    <= 1'b1;
      r_data    <= 1'b0;
      r_bit_cnt <= CNT_LAST;
      r_shreg   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, as in hardware.
      r_presc <= w_tc ? '0 : r_presc + 1'b1;
      if (w_tc) r_bclk <= ~r_bclk;
      if (w_fall) begin
        r_bit_cnt <= w_cnt_next;
        r_data    <= r_shreg[FW-1];
        r_shreg   <= w_load ? w_frame : {r_shreg[FW-2:0], 1'b0};
        if (w_cnt_next == '0)            r_lrck <= 1'b0;
        else if (w_cnt_next == CNT_RIGHT) r_lrck <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold       <= '0;
      r_last       <= '0;
      r_hold_valid <= 1'b0;
      r_sample_req <= 1'b0;
      r_underrun   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sample_req <= w_load;
      r_underrun   <= w_load && !audio_en && !r_hold_valid;
      r_overrun    <= !w_load && audio_en && r_hold_valid;
      if (w_load) begin
        r_last       <= w_frame;
        r_hold_valid <= 1'b0;
      end else if (audio_en) begin
        r_hold       <= w_sample;
        r_hold_valid <= 1'b1;
      end
    end
  end

  assign i2s_bclk   = r_bclk;
  assign i2s_lrck   = r_lrck;
  assign i2s_data   = r_data;
  assign sample_req = r_sample_req;
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a cycle-count/frame-list reference model predicts every
// output on every clk; stimulus mixes directed scenarios with random strobes.
module tb_audio_i2s_tx;

  localparam int W     = 16;
  localparam int D     = 2;
  localparam int FW    = 2 * W;
  localparam int FRAME = 4 * W * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         audio_en = 1'b0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic         i2s_bclk, i2s_lrck, i2s_data, sample_req, underrun, overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: clk edges since reset release, pending sample, and
  // the list of frames in the order they were put on the wire.
  int              m_c = 0;
  logic            m_hv = 1'b0;
  logic [FW-1:0]   m_hold = '0;
  logic [FW-1:0]   m_last = '0;
  logic [FW-1:0]   m_frames[$];
  logic            e_sreq = 1'b0, e_under = 1'b0, e_over = 1'b0;

  audio_i2s_tx #(.WIDTH(W), .BCLK_DIV(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_en   (audio_en),
    .left       (left),
    .right      (right),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_data   (i2s_data),
    .sample_req (sample_req),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bit is_load;
    if (!rst_n) begin
      m_c = 0; m_hv = 1'b0; m_hold = '0; m_last = '0;
      m_frames.delete();
      e_sreq = 1'b0; e_under = 1'b0; e_over = 1'b0;
    end else begin
      m_c++;
      is_load = (m_c >= 2 * D) && (((m_c - 2 * D) % FRAME) == 0);
      e_sreq = is_load; e_under = 1'b0; e_over = 1'b0;
      if (is_load) begin
        if (audio_en) begin
          m_last = {left, right}; m_hv = 1'b0;
        end else if (m_hv) begin
          m_last = m_hold; m_hv = 1'b0;
        end else begin
          e_under = 1'b1;
        end
        m_frames.push_back(m_last);
      end else if (audio_en) begin
        e_over = m_hv; m_hold = {left, right}; m_hv = 1'b1;
      end
    end
  end

  function automatic logic exp_bclk();
    return logic'((m_c / D) % 2);
  endfunction

  function automatic logic exp_lrck();
    if (m_c < 2 * D) return 1'b1;
    return logic'(((m_c - 2 * D) / (FW * D)) % 2);
  endfunction

  // Bit k on the wire (k-th fall event after release) is bit (k-1)%FW, MSB first,
  // of frame (k-1)/FW; the very first fall shifts out the cleared register.
  function automatic logic exp_data();
    int k, f, i;
    logic [FW-1:0] fr;
    if (m_c < 2 * D) return 1'b0;
    k = (m_c - 2 * D) / (2 * D);
    if (k == 0) return 1'b0;
    f = (k - 1) / FW;
    i = (k - 1) % FW;
    if (f >= m_frames.size()) return 1'bx;
    fr = m_frames[f];
    return fr[FW-1-i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, m_c);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("bclk",       i2s_bclk,   exp_bclk());
    check("lrck",       i2s_lrck,   exp_lrck());
    check("data",       i2s_data,   exp_data());
    check("sample_req", sample_req, e_sreq);
    check("underrun",   underrun,   e_under);
    check("overrun",    overrun,    e_over);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic [W-1:0] l, input logic [W-1:0] r);
    audio_en = 1'b1; left = l; right = r;
    tick();
    audio_en = 1'b0;
  endtask

  // Advance until the coming clk edge is a frame load.
  task automatic run_to_pre_load();
    int n = 0;
    while (!((m_c + 1 >= 2 * D) && (((m_c + 1 - 2 * D) % FRAME) == 0)) && n < 2 * FRAME) begin
      tick(); n++;
    end
    check("pre_load_timeout", n < 2 * FRAME, 1'b1);
  endtask

  // Advance until the last edge sits at the given offset into the frame.
  task automatic run_to_offset(input int off);
    int n = 0;
    while (!((m_c >= 2 * D) && (((m_c - 2 * D) % FRAME) == off)) && n < 2 * FRAME) begin
      tick(); n++;
    end
    check("offset_timeout", n < 2 * FRAME, 1'b1);
  endtask

  initial begin
    // Reset state, then sample queued before the first frame load.
    run(3);
    rst_n = 1'b1;
    strobe(16'h8001, 16'h7FFE);
    run(3 * FRAME);

    // Two strobes inside one frame: overrun, newer sample wins.
    run_to_offset(10);
    strobe(16'h1234, 16'h5678);
    run_to_offset(60);
    strobe(16'hAAAA, 16'h5555);
    run(2 * FRAME);

    // Strobe coincident with the frame load bypasses the hold buffer.
    run_to_pre_load();
    strobe(16'hC3A5, 16'h0F1E);
    run(FRAME);
    run_to_pre_load();
    strobe(W'($urandom), W'($urandom));
    run(FRAME);

    // Random strobes; coincident strobes only where nothing is pending.
    repeat (8 * FRAME) begin
      if ($urandom_range(0, 63) == 0 &&
          !(m_hv && (((m_c + 1 - 2 * D) % FRAME) == 0)))
        strobe(W'($urandom), W'($urandom));
      else
        tick();
    end

    // Mid-frame reset with a sample pending: async response and clean restart.
    run_to_offset(40);
    strobe(W'($urandom), W'($urandom));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_bclk", i2s_bclk,   1'b0);
    check("rst_async_lrck", i2s_lrck,   1'b1);
    check("rst_async_data", i2s_data,   1'b0);
    check("rst_async_sreq", sample_req, 1'b0);
    check("rst_async_undr", underrun,   1'b0);
    check("rst_async_ovr",  overrun,    1'b0);
    run(3);
    rst_n = 1'b1;
    run(2 * FRAME);

    // Free-running frames: one new sample, then repeats with underruns.
    strobe(W'($urandom), W'($urandom));
    run(10 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter WIDTH, 16, bits per channel sample.
REQ-002 Parameter BCLK_DIV, 4, clk cycles per BCLK half-period; legal values are 2 or more.
REQ-003 clk  in  1  system clock; all logic SHALL be clocked on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 audio_en  in  1  one-cycle strobe; left/right are valid on this cycle.
REQ-006 left  in  WIDTH  signed left-channel sample, output of the DC filter stage.
REQ-007 right  in  WIDTH  signed right-channel sample.
REQ-008 i2s_bclk  out  1  bit clock, registered.
REQ-009 i2s_lrck  out  1  word select, registered; 0 = left, 1 = right.
REQ-010 i2s_data  out  1  serial data, registered, MSB first.
REQ-011 sample_req  out  1  one-cycle pulse on each frame load.
REQ-012 underrun  out  1  one-cycle pulse when a frame load finds no new sample.
REQ-013 overrun  out  1  one-cycle pulse when a pending sample is overwritten.

Function
REQ-014 Prescaler SHALL count 0..BCLK_DIV-1; at terminal count it SHALL wrap to 0 and toggle i2s_bclk.
REQ-015 A "fall event" is the clk cycle on which i2s_bclk toggles 1->0; bit_cnt (0..2*WIDTH-1) SHALL advance by one, with wrap, on each fall event only.
REQ-016 On a fall event where bit_cnt becomes 0, i2s_lrck SHALL go 0; where bit_cnt becomes WIDTH, i2s_lrck SHALL go 1.
REQ-017 On every fall event i2s_data SHALL take shreg[2*WIDTH-1], then the 2*WIDTH-bit shreg SHALL shift left by one with 0 fill.
REQ-018 On a fall event where bit_cnt becomes 0 (frame load), shreg SHALL be loaded with {left frame, right frame} after the REQ-017 sample is taken, giving the one-BCLK I2S data delay after each LRCK edge.
REQ-019 Hold buffer: on audio_en, {left,right} SHALL be written to hold and hold_valid set.
REQ-020 Frame load with hold_valid=1 SHALL load hold into shreg, copy it into last_frame, and clear hold_valid.
REQ-021 Frame load with hold_valid=0 and no audio_en SHALL reload last_frame and pulse underrun.
REQ-022 audio_en on the same cycle as a frame load SHALL bypass hold: left/right load directly into shreg and last_frame, hold_valid remains 0, and neither overrun nor underrun pulses.
REQ-023 audio_en while hold_valid=1, other than the REQ-022 case, SHALL overwrite hold and pulse overrun.
REQ-024 sample_req SHALL pulse on every frame load, whether or not an underrun occurs.
REQ-025 Samples SHALL be transmitted bit-exact, with no scaling or saturation.
REQ-026 Frame period SHALL be exactly 4*WIDTH*BCLK_DIV clk cycles.
REQ-027 Pulse outputs SHALL be registered and asserted on the clk cycle following the causing event.

Reset
REQ-028 While rst_n=0: i2s_bclk=0, i2s_lrck=1, i2s_data=0, pulses=0, prescaler=0, bit_cnt=2*WIDTH-1, shreg=0, hold=0, last_frame=0, hold_valid=0.
REQ-029 After release, the first rising BCLK SHALL occur at clk edge BCLK_DIV, and the first fall event (frame load, i2s_lrck->0) at clk edge 2*BCLK_DIV.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, discard pending hold, and restart per REQ-029.

Verification (WIDTH=16, BCLK_DIV=2)
REQ-031 audio_en with left=0x8001, right=0x7FFE before the first frame load -> data after the LRCK fall reads bits 1,0,...,0,1; after the LRCK rise it reads 0,1,...,1,0; sample_req pulses each 128 clk.
REQ-032 No audio_en after one loaded frame -> the next frame repeats 0x8001/0x7FFE and underrun pulses once per frame.
REQ-033 Two audio_en strobes (0x1234/0x5678, then 0xAAAA/0x5555) within one frame -> overrun pulses once; the next frame carries 0xAAAA/0x5555.
REQ-034 audio_en coincident with a fall event where bit_cnt becomes 0 -> that frame carries the new sample; no overrun or underrun pulse.
REQ-035 rst_n low for 3 clk in mid-frame -> outputs take reset values asynchronously; after release, BCLK rises at clk edge 2 and the frame load occurs at clk edge 4.
REQ-036 Free-running check over 10 frames -> i2s_bclk period is 4 clk, LRCK toggles every 64 clk, and i2s_data changes only on fall events.
